// File: rtl/xor_pipe_unit.sv
// Pipelined WIDTH-bit XOR/XNOR/accumulate/parity engine with a valid/ready handshake.
// Results leave in accept order after STAGES cycles; the whole pipe stalls as one unit.
module xor_pipe_unit #(
   parameter int WIDTH  = 8,
   parameter int STAGES = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic [1:0]       mode,
   input  logic             acc_clr,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] acc_value
);

   localparam logic [1:0] MODE_XOR    = 2'b00;
   localparam logic [1:0] MODE_XNOR   = 2'b01;
   localparam logic [1:0] MODE_ACCUM  = 2'b10;
   localparam logic [1:0] MODE_PARITY = 2'b11;

   logic             w_adv;
   logic             w_accept;
   logic [WIDTH-1:0] w_ab;
   logic [WIDTH-1:0] w_acc_base;
   logic [WIDTH-1:0] w_acc_next;
   logic [WIDTH-1:0] w_result;

   logic [WIDTH-1:0] r_acc;
   logic             r_valid [STAGES];
   logic [WIDTH-1:0] r_data  [STAGES];

   // Advance depends only on the registered output stage, so in_ready has no path from the operands.
   assign w_adv    = !r_valid[STAGES-1] || out_ready;
   assign w_accept = in_valid && w_adv;

   // A coincident clear wins over the old accumulator contents.
   assign w_ab       = in_a ^ in_b;
   assign w_acc_base = acc_clr ? '0 : r_acc;
   assign w_acc_next = w_acc_base ^ w_ab;

   always_comb begin
      w_result = w_ab;
      case (mode)
         MODE_XOR:    w_result = w_ab;
         MODE_XNOR:   w_result = ~w_ab;
         MODE_ACCUM:  w_result = w_acc_next;
         MODE_PARITY: begin
            w_result    = '0;
            w_result[0] = ^w_ab;
         end
         default:     w_result = w_ab;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_acc <= '0;
      end else if (w_accept && (mode == MODE_ACCUM)) begin
         r_acc <= w_acc_next;
      end else if (acc_clr) begin
         r_acc <= '0;
      end
   end

   // Bubbles travel like data; nothing moves while the output is blocked.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < STAGES; i++) begin
            r_valid[i] <= 1'b0;
            r_data[i]  <= '0;
         end
      end else if (w_adv) begin
         r_valid[0] <= in_valid;
         r_data[0]  <= w_result;
         for (int i = 1; i < STAGES; i++) begin
            r_valid[i] <= r_valid[i-1];
            r_data[i]  <= r_data[i-1];
         end
      end
   end

   assign in_ready  = w_adv;
   assign out_valid = r_valid[STAGES-1];
   assign out_data  = r_data[STAGES-1];
   assign acc_value = r_acc;

endmodule

// File: tb/tb_xor_pipe_unit.sv
// Bench for xor_pipe_unit: per-configuration scoreboard model plus directed literal checks
// on the 8-bit/2-stage build and random handshake traffic on all builds.
module tb_xor_pipe_unit;

   localparam int NCFG = 5;

   typedef struct {
      logic [31:0] d;
      int          acyc;
      int          astall;
      bit          seen;
   } item_t;

   logic            clk = 1'b0;
   int              errors = 0;
   int              checks = 0;
   logic [NCFG-1:0] done = '0;

   always #5 clk = ~clk;

   function automatic int cfg_w(input int i);
      case (i)
         0:       return 8;
         1:       return 1;
         2:       return 8;
         default: return 32;
      endcase
   endfunction

   function automatic int cfg_s(input int i);
      case (i)
         0:       return 2;
         1:       return 1;
         2:       return 3;
         3:       return 3;
         default: return 1;
      endcase
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
      end
   endtask

   for (genvar gi = 0; gi < NCFG; gi++) begin : g_cfg
      localparam int W = cfg_w(gi);
      localparam int S = cfg_s(gi);

      logic         rst_n;
      logic         in_valid;
      logic         in_ready;
      logic         out_valid;
      logic         out_ready;
      logic         acc_clr;
      logic [1:0]   mode;
      logic [W-1:0] in_a;
      logic [W-1:0] in_b;
      logic [W-1:0] out_data;
      logic [W-1:0] acc_value;

      xor_pipe_unit #(.WIDTH(W), .STAGES(S)) u_dut (
         .clk       (clk),
         .rst_n     (rst_n),
         .in_a      (in_a),
         .in_b      (in_b),
         .mode      (mode),
         .acc_clr   (acc_clr),
         .in_valid  (in_valid),
         .in_ready  (in_ready),
         .out_data  (out_data),
         .out_valid (out_valid),
         .out_ready (out_ready),
         .acc_value (acc_value)
      );

      item_t        q[$];
      logic [31:0]  got[$];
      logic [W-1:0] m_acc = '0;
      int           cyc = 0;
      int           stalls = 0;
      bit           armed = 1'b0;
      bit           rst_seen = 1'b0;

      function automatic string nm(input string s);
         return $sformatf("cfg%0d %s", gi, s);
      endfunction

      // Reference model: results queued in accept order; a result is due STAGES cycles
      // after accept plus one cycle for every cycle the output sat blocked.
      initial begin : p_model
         logic [W-1:0] base;
         logic [W-1:0] res;
         item_t        it;
         int           el;
         forever begin
            @(negedge clk);
            if (armed) begin
               if (rst_seen) begin
                  chk(nm("reset out_valid"), 32'(out_valid), 32'd0);
                  chk(nm("reset out_data"), 32'(out_data), 32'd0);
               end
               chk(nm("in_ready"), 32'(in_ready), 32'(!out_valid || out_ready));
               chk(nm("acc_value"), 32'(acc_value), 32'(m_acc));
               if (out_valid) begin
                  chk(nm("out_valid with nothing pending"), 32'(out_valid), 32'(q.size() != 0));
                  if (q.size() != 0) begin
                     chk(nm("out_data"), 32'(out_data), q[0].d);
                     if (!q[0].seen) begin
                        q[0].seen = 1'b1;
                        el = cyc - q[0].acyc - (stalls - q[0].astall);
                        chk(nm("latency"), 32'(el), 32'(S));
                     end
                  end
               end else if (q.size() != 0) begin
                  el = cyc - q[0].acyc - (stalls - q[0].astall);
                  if (el > S) begin
                     chk(nm("result overdue"), 32'(out_valid), 32'd1);
                     void'(q.pop_front());
                  end
               end
            end
            rst_seen = 1'b0;
            if (rst_n !== 1'b1) begin
               q.delete();
               m_acc    = '0;
               rst_seen = 1'b1;
               armed    = 1'b1;
            end else if (armed) begin
               if (out_valid && out_ready && q.size() != 0) begin
                  got.push_back(32'(out_data));
                  void'(q.pop_front());
               end else if (out_valid && !out_ready) begin
                  stalls++;
               end
               if (in_valid && in_ready) begin
                  base = acc_clr ? '0 : m_acc;
                  case (mode)
                     2'd0:    res = in_a ^ in_b;
                     2'd1:    res = ~(in_a ^ in_b);
                     2'd2:    res = base ^ in_a ^ in_b;
                     default: begin
                        res    = '0;
                        res[0] = ^(in_a ^ in_b);
                     end
                  endcase
                  it.d      = 32'(res);
                  it.acyc   = cyc;
                  it.astall = stalls;
                  it.seen   = 1'b0;
                  q.push_back(it);
                  if (mode == 2'd2) m_acc = res;
                  else if (acc_clr) m_acc = '0;
               end else if (acc_clr) begin
                  m_acc = '0;
               end
            end
            cyc++;
         end
      end

      task automatic tick();
         @(posedge clk);
         #1;
      endtask

      task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [1:0] m,
                          input logic clr);
         bit ok;
         in_a     = a[W-1:0];
         in_b     = b[W-1:0];
         mode     = m;
         acc_clr  = clr;
         in_valid = 1'b1;
         ok       = 1'b0;
         for (int k = 0; k < 50 && !ok; k++) begin
            @(negedge clk);
            ok = in_ready;
            tick();
         end
         if (!ok) chk(nm("send accepted"), 32'(in_ready), 32'd1);
         in_valid = 1'b0;
         acc_clr  = 1'b0;
      endtask

      task automatic drain();
         in_valid  = 1'b0;
         acc_clr   = 1'b0;
         out_ready = 1'b1;
         for (int k = 0; k < S + 20 && q.size() != 0; k++) tick();
         chk(nm("drained"), 32'(q.size()), 32'd0);
      endtask

      task automatic run_random(input int n);
         logic [31:0] r;
         for (int k = 0; k < n; k++) begin
            r         = $urandom;
            in_a      = r[W-1:0];
            r         = $urandom;
            in_b      = r[W-1:0];
            mode      = 2'($urandom_range(0, 3));
            acc_clr   = ($urandom_range(0, 9) == 0);
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 7);
            tick();
         end
         drain();
      endtask

      if (gi == 0) begin : g_dir
         initial begin
            int n0;
            rst_n     = 1'b0;
            in_valid  = 1'b1;
            in_a      = '1;
            in_b      = '0;
            mode      = 2'd0;
            acc_clr   = 1'b0;
            out_ready = 1'b1;
            repeat (3) @(posedge clk);
            #1;
            rst_n    = 1'b1;
            in_valid = 1'b0;
            @(negedge clk);
            chk(nm("t1 in_ready"), 32'(in_ready), 32'd1);
            chk(nm("t1 out_valid"), 32'(out_valid), 32'd0);
            chk(nm("t1 acc_value"), 32'(acc_value), 32'd0);
            tick();

            n0 = got.size();
            send(32'hA5, 32'h0F, 2'd0, 1'b0);
            send(32'hA5, 32'h0F, 2'd1, 1'b0);
            send(32'hA5, 32'h0F, 2'd3, 1'b0);
            send(32'h01, 32'h00, 2'd3, 1'b0);
            drain();
            chk(nm("t2 count"), 32'(got.size() - n0), 32'd4);
            chk(nm("t2 xor"), got[n0], 32'hAA);
            chk(nm("t2 xnor"), got[n0+1], 32'h55);
            chk(nm("t2 parity0"), got[n0+2], 32'h00);
            chk(nm("t2 parity1"), got[n0+3], 32'h01);

            n0 = got.size();
            send(32'h11, 32'h00, 2'd2, 1'b0);
            send(32'h22, 32'h00, 2'd2, 1'b0);
            send(32'h0F, 32'h0F, 2'd2, 1'b0);
            drain();
            chk(nm("t3 acc0"), got[n0], 32'h11);
            chk(nm("t3 acc1"), got[n0+1], 32'h33);
            chk(nm("t3 acc2"), got[n0+2], 32'h33);
            chk(nm("t3 acc_value"), 32'(acc_value), 32'h33);
            send(32'h44, 32'h00, 2'd2, 1'b1);
            drain();
            chk(nm("t3 clr+accum"), got[n0+3], 32'h44);
            chk(nm("t3 acc after clr"), 32'(acc_value), 32'h44);

            n0 = got.size();
            fork
               begin
                  for (int i = 1; i <= 5; i++) send(32'(i), 32'(i << 4), 2'd0, 1'b0);
               end
               begin
                  repeat (3) @(posedge clk);
                  #1;
                  out_ready = 1'b0;
                  @(negedge clk);
                  chk(nm("t4 stall in_ready"), 32'(in_ready), 32'd0);
                  chk(nm("t4 stall out_valid"), 32'(out_valid), 32'd1);
                  repeat (4) tick();
                  out_ready = 1'b1;
               end
            join
            drain();
            chk(nm("t4 count"), 32'(got.size() - n0), 32'd5);
            for (int i = 1; i <= 5; i++) chk(nm("t4 order"), got[n0+i-1], 32'(i * 32'h11));

            n0 = got.size();
            send(32'h12, 32'h00, 2'd2, 1'b0);
            send(32'h01, 32'h00, 2'd2, 1'b0);
            rst_n = 1'b0;
            tick();
            rst_n = 1'b1;
            @(negedge clk);
            chk(nm("t5 out_valid"), 32'(out_valid), 32'd0);
            chk(nm("t5 acc_value"), 32'(acc_value), 32'd0);
            repeat (4) tick();
            chk(nm("t5 dropped"), 32'(got.size() - n0), 32'd0);

            run_random(400);
            done[gi] = 1'b1;
         end
      end else begin : g_rnd
         initial begin
            rst_n     = 1'b0;
            in_valid  = 1'b0;
            in_a      = '0;
            in_b      = '0;
            mode      = 2'd0;
            acc_clr   = 1'b0;
            out_ready = 1'b1;
            repeat (3) @(posedge clk);
            #1;
            rst_n = 1'b1;
            run_random(400);
            done[gi] = 1'b1;
         end
      end
   end

   initial begin
      for (int c = 0; c < 20000 && !(&done); c++) @(posedge clk);
      if (!(&done)) chk("timeout done flags", 32'(done), 32'((1 << NCFG) - 1));
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
